// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// Pipeline register carrying one instruction and its PC+4, with load, hold
// and flush controls. A flush injects the bubble word but keeps pc4 as-is.
module if_id_reg
#(
    parameter logic [31:0] FLUSH_INSTR = if_fetch_stage_pkg::NOP_INSTR
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o,
    output logic [5:0]  op_o,
    output logic [5:0]  func_o
);
    import if_fetch_stage_pkg::*;

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Register update: flush beats load; otherwise hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= FLUSH_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= FLUSH_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;
    assign op_o    = instr_q[OP_MSB:OP_LSB];
    assign func_o  = instr_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, runs a single-outstanding req/ack fetch,
// buffers one response behind a decode stall and squashes wrong-path data
// after a redirect.
//
//   state | meaning
//   IDLE  | first cycle out of reset, no request yet
//   FETCH | request to imem is asserted at pc
//   HOLD  | a response sits in the skid buffer waiting for stall to drop
module if_fetch_stage
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  ifid_op,
    output logic [5:0]  ifid_func
);
    import if_fetch_stage_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic         kill_q, kill_d;
    logic         hold_valid_q, hold_valid_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;

    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_d_instr;
    logic [31:0]  ifid_d_pc4;

    logic         req;
    logic         resp_fire;
    logic [31:0]  pc_plus4;

    assign req       = (state_q == FETCH);
    assign resp_fire = req & imem_ack;
    assign pc_plus4  = pc_q + PC_INC;
    assign imem_req  = req;
    assign imem_addr = pc_q;

    // Next-state, PC and IF/ID control; redirect has priority over all else.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        kill_d        = kill_q;
        hold_valid_d  = hold_valid_q;
        hold_instr_d  = hold_instr_q;
        hold_pc4_d    = hold_pc4_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_d_instr  = imem_rdata;
        ifid_d_pc4    = pc_plus4;

        if (pcsrc) begin
            ifid_flush   = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = FETCH;
            if (!req || imem_ack) begin
                // Nothing in flight, or the in-flight word lands now and is dropped.
                pc_d   = align_word(branch_target);
                kill_d = 1'b0;
            end else begin
                // Address must stay put until the pending response returns.
                redirect_pc_d = align_word(branch_target);
                kill_d        = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (resp_fire) begin
                        if (kill_q) begin
                            pc_d   = redirect_pc_q;
                            kill_d = 1'b0;
                        end else begin
                            pc_d = pc_plus4;
                            if (!stall && !hold_valid_q) begin
                                ifid_load = 1'b1;
                            end else begin
                                hold_instr_d = imem_rdata;
                                hold_pc4_d   = pc_plus4;
                                hold_valid_d = 1'b1;
                                state_d      = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load    = 1'b1;
                        ifid_d_instr = hold_instr_q;
                        ifid_d_pc4   = hold_pc4_q;
                        hold_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 32'd0;
            kill_q        <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_instr_q  <= 32'd0;
            hold_pc4_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            kill_q        <= kill_d;
            hold_valid_q  <= hold_valid_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc4_q    <= hold_pc4_d;
        end
    end

    if_id_reg #(
        .FLUSH_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (ifid_d_instr),
        .pc4_i   (ifid_d_pc4),
        .instr_o (ifid_instr),
        .pc4_o   (ifid_pc4),
        .valid_o (ifid_valid),
        .op_o    (ifid_op),
        .func_o  (ifid_func)
    );

endmodule
